// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the restoring divider.
package divider_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Iteration counter width: must index 0 .. width-1, never narrower than 1 bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/cl_subtractor.sv
// Add/subtract unit: sum_o = a_i + (b_i ^ {sub_i}) + sub_i, c_o = carry out.
// In subtract mode c_o = 1 means a_i >= b_i (no borrow).
module cl_subtractor #(
  parameter int Width = 9
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
  output logic [Width-1:0] sum_o,
  output logic             c_o
);

  logic [Width-1:0] b_x;
  logic [Width-1:0] gen;
  logic [Width-1:0] prop;
  logic [Width:0]   carry;

  // Per-bit generate/propagate terms on the conditionally inverted operand.
  generate
    for (genvar gi = 0; gi < Width; gi++) begin : g_gp
      assign b_x[gi]  = b_i[gi] ^ sub_i;
      assign gen[gi]  = a_i[gi] & b_x[gi];
      assign prop[gi] = a_i[gi] ^ b_x[gi];
    end
  endgenerate

  // Carry chain; sub_i doubles as the +1 of the two's complement.
  always_comb begin
    carry    = '0;
    carry[0] = sub_i;
    for (int i = 0; i < Width; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  // Sum bits from propagate and incoming carry.
  generate
    for (genvar gi = 0; gi < Width; gi++) begin : g_sum
      assign sum_o[gi] = prop[gi] ^ carry[gi];
    end
  endgenerate

  assign c_o = carry[Width];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: RESTORING_DIVIDER_DBZ_EN (zero divisor short-cuts
// straight to the result and raises div_by_zero_o).
module restoring_divider
  import divider_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [Width-1:0] quotient_o,
  output logic [Width-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CntW = cnt_width(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  state_t           state_reg, state_next;
  logic [CntW-1:0]  cnt_reg;
  logic [Width:0]   p_reg;
  logic [Width-1:0] q_reg;
  logic [Width:0]   d_reg;
  logic [Width-1:0] quotient_reg;
  logic [Width-1:0] remainder_reg;

  logic [Width:0]   p_shift;
  logic [Width:0]   diff;
  logic             no_borrow;
  logic [Width:0]   p_new;
  logic [Width-1:0] q_new;
  logic             last_iter;
  logic             divisor_zero;
  logic             p_msb_unused;

  // P[Width] only carries intermediate weight; it is never read back.
  assign p_msb_unused = p_reg[Width];

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign p_shift = {p_reg[Width-1:0], q_reg[Width-1]};

  cl_subtractor #(
    .Width (Width + 1)
  ) u_sub (
    .a_i   (p_shift),
    .b_i   (d_reg),
    .sub_i (1'b1),
    .sum_o (diff),
    .c_o   (no_borrow)
  );

  assign p_new     = no_borrow ? diff : p_shift;
  assign q_new     = {q_reg[Width-2:0], no_borrow};
  assign last_iter = (cnt_reg == LastCnt);

`ifdef RESTORING_DIVIDER_DBZ_EN
  logic dbz_reg;

  assign divisor_zero = (divisor_i == '0);

  // Flag follows each accepted start, so it clears on the next good request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dbz_reg <= 1'b0;
    end else if ((state_reg == S_IDLE) && start_i) begin
      dbz_reg <= divisor_zero;
    end
  end

  assign div_by_zero_o = dbz_reg;
`else
  assign divisor_zero  = 1'b0;
  assign div_by_zero_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; starts outside S_IDLE are simply ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          state_next = divisor_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy_o  = (state_reg != S_IDLE);
    valid_o = (state_reg == S_DONE);
  end

  // Working registers and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg       <= '0;
      p_reg         <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            q_reg   <= dividend_i;
            p_reg   <= '0;
            d_reg   <= {1'b0, divisor_i};
            cnt_reg <= '0;
            if (divisor_zero) begin
              quotient_reg  <= '1;
              remainder_reg <= dividend_i;
            end
          end
        end
        S_CALC: begin
          p_reg   <= p_new;
          q_reg   <= q_new;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_iter) begin
            quotient_reg  <= q_new;
            remainder_reg <= p_new[Width-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient_o  = quotient_reg;
  assign remainder_o = remainder_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and randomized checks for restoring_divider (Width = 8).
module tb_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int tests_run    = 0;
  int tests_failed = 0;

  // Results captured by run_div.
  logic [W-1:0] res_q;
  logic [W-1:0] res_r;
  logic         res_dbz;
  int           res_lat;
  int           res_busy;
  logic         res_busy_after;
  logic         res_valid_after;
  logic         res_timeout;

  restoring_divider #(
    .Width (W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .busy_o        (busy),
    .valid_o       (valid),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .div_by_zero_o (dbz)
  );

  always #5 clk = ~clk;

  // Issue one division from S_IDLE and wait (bounded) for valid_o.
  // res_lat counts cycles after the start edge: 1 = cycle right after it.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] d);
    start    = 1'b1;
    dividend = a;
    divisor  = d;
    @(posedge clk); #1;
    start       = 1'b0;
    res_lat     = 1;
    res_busy    = 0;
    res_timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (busy) res_busy++;
      if (valid) begin
        res_timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
      res_lat++;
    end
    res_q   = quotient;
    res_r   = remainder;
    res_dbz = dbz;
    @(posedge clk); #1;
    res_busy_after  = busy;
    res_valid_after = valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid); end
    tests_run++; if (quotient !== 8'd0) begin tests_failed++; $display("FAIL reset_q: got %0d expected 0", quotient); end
    tests_run++; if (remainder !== 8'd0) begin tests_failed++; $display("FAIL reset_r: got %0d expected 0", remainder); end
    tests_run++; if (dbz !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("[TB] reset: busy=%b valid=%b q=%0d r=%0d", busy, valid, quotient, remainder);
  endtask

  task automatic test_basic();
    run_div(8'd100, 8'd7);
    $display("[TB] 100/7 -> q=%0d r=%0d lat=%0d busy=%0d", res_q, res_r, res_lat, res_busy);
    tests_run++; if (res_timeout !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout: no valid_o within budget"); end
    tests_run++; if (res_q !== 8'd14) begin tests_failed++; $display("FAIL basic_q: got %0d expected 14", res_q); end
    tests_run++; if (res_r !== 8'd2) begin tests_failed++; $display("FAIL basic_r: got %0d expected 2", res_r); end
    tests_run++; if (res_dbz !== 1'b0) begin tests_failed++; $display("FAIL basic_dbz: got %b expected 0", res_dbz); end
    tests_run++; if (res_lat != 9) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 9", res_lat); end
    tests_run++; if (res_busy != 9) begin tests_failed++; $display("FAIL basic_busy_cycles: got %0d expected 9", res_busy); end
    tests_run++; if (res_busy_after !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_drop: got %b expected 0", res_busy_after); end
    tests_run++; if (res_valid_after !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_pulse: got %b expected 0", res_valid_after); end
  endtask

  task automatic test_vectors();
    // {dividend, divisor, quotient, remainder}
    logic [31:0] vec [8];
    vec[0] = {8'd255, 8'd1,   8'd255, 8'd0};
    vec[1] = {8'd5,   8'd9,   8'd0,   8'd5};
    vec[2] = {8'd200, 8'd200, 8'd1,   8'd0};
    vec[3] = {8'd0,   8'd5,   8'd0,   8'd0};
    vec[4] = {8'd255, 8'd255, 8'd1,   8'd0};
    vec[5] = {8'd254, 8'd255, 8'd0,   8'd254};
    vec[6] = {8'd128, 8'd2,   8'd64,  8'd0};
    vec[7] = {8'd200, 8'd7,   8'd28,  8'd4};
    for (int i = 0; i < 8; i++) begin
      run_div(vec[i][31:24], vec[i][23:16]);
      $display("[TB] %0d/%0d -> q=%0d r=%0d lat=%0d", vec[i][31:24], vec[i][23:16], res_q, res_r, res_lat);
      tests_run++; if (res_q !== vec[i][15:8]) begin tests_failed++; $display("FAIL vec%0d_q: got %0d expected %0d", i, res_q, vec[i][15:8]); end
      tests_run++; if (res_r !== vec[i][7:0]) begin tests_failed++; $display("FAIL vec%0d_r: got %0d expected %0d", i, res_r, vec[i][7:0]); end
      tests_run++; if (res_lat != 9) begin tests_failed++; $display("FAIL vec%0d_latency: got %0d expected 9", i, res_lat); end
    end
  endtask

  task automatic test_div_by_zero();
    int   exp_lat;
    logic exp_dbz;
`ifdef RESTORING_DIVIDER_DBZ_EN
    exp_lat = 1;
    exp_dbz = 1'b1;
`else
    exp_lat = 9;
    exp_dbz = 1'b0;
`endif
    run_div(8'h2A, 8'h00);
    $display("[TB] 0x2A/0 -> q=0x%02h r=0x%02h dbz=%b lat=%0d", res_q, res_r, res_dbz, res_lat);
    tests_run++; if (res_q !== 8'hFF) begin tests_failed++; $display("FAIL dbz_q: got 0x%02h expected 0xFF", res_q); end
    tests_run++; if (res_r !== 8'h2A) begin tests_failed++; $display("FAIL dbz_r: got 0x%02h expected 0x2A", res_r); end
    tests_run++; if (res_dbz !== exp_dbz) begin tests_failed++; $display("FAIL dbz_flag: got %b expected %b", res_dbz, exp_dbz); end
    tests_run++; if (res_lat != exp_lat) begin tests_failed++; $display("FAIL dbz_latency: got %0d expected %0d", res_lat, exp_lat); end
    tests_run++; if (res_busy_after !== 1'b0) begin tests_failed++; $display("FAIL dbz_busy_drop: got %b expected 0", res_busy_after); end
    // A following good division must clear the flag.
    run_div(8'd9, 8'd4);
    $display("[TB] 9/4 after zero divisor -> q=%0d r=%0d dbz=%b", res_q, res_r, res_dbz);
    tests_run++; if (res_dbz !== 1'b0) begin tests_failed++; $display("FAIL dbz_clear: got %b expected 0", res_dbz); end
    tests_run++; if (res_q !== 8'd2 || res_r !== 8'd1) begin tests_failed++; $display("FAIL dbz_next_result: got %0d/%0d expected 2/1", res_q, res_r); end
  endtask

  task automatic test_ignored_start();
    int lat;
    logic seen;
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;                       // cycle 1
    repeat (3) begin @(posedge clk); #1; end  // cycle 4
    start = 1'b1; dividend = 8'd50; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 5;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    $display("[TB] ignored start: q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL ign_timeout: no valid_o within budget"); end
    tests_run++; if (quotient !== 8'd14 || remainder !== 8'd2) begin tests_failed++; $display("FAIL ign_result: got %0d/%0d expected 14/2", quotient, remainder); end
    tests_run++; if (lat != 9) begin tests_failed++; $display("FAIL ign_latency: got %0d expected 9", lat); end
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ign_no_queue: busy got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;                       // cycle 1
    repeat (4) begin @(posedge clk); #1; end  // cycle 5
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("[TB] mid reset: busy=%b valid=%b q=%0d r=%0d", busy, valid, quotient, remainder);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b expected 0", busy); end
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid: got %b expected 0", valid); end
    tests_run++; if (quotient !== 8'd0 || remainder !== 8'd0) begin tests_failed++; $display("FAIL mid_outputs: got %0d/%0d expected 0/0", quotient, remainder); end
    tests_run++; if (dbz !== 1'b0) begin tests_failed++; $display("FAIL mid_dbz: got %b expected 0", dbz); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (valid) seen = 1'b1;
    end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL mid_no_valid: got pulse expected none"); end
    run_div(8'd60, 8'd8);
    $display("[TB] 60/8 after reset -> q=%0d r=%0d", res_q, res_r);
    tests_run++; if (res_q !== 8'd7 || res_r !== 8'd4) begin tests_failed++; $display("FAIL mid_fresh: got %0d/%0d expected 7/4", res_q, res_r); end
  endtask

  task automatic test_back_to_back();
    int   n;
    logic seen;
    logic idle_gap;
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid) begin seen = 1'b1; break; end
    end
    tests_run++; if (seen !== 1'b1 || quotient !== 8'd14) begin tests_failed++; $display("FAIL b2b_first: got q=%0d expected 14", quotient); end
    dividend = 8'd60; divisor = 8'd8;   // start stays high
    n = 0;
    seen = 1'b0;
    idle_gap = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) idle_gap = ~busy;
      if (valid) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    $display("[TB] back-to-back: q=%0d r=%0d spacing=%0d", quotient, remainder, n);
    tests_run++; if (idle_gap !== 1'b1) begin tests_failed++; $display("FAIL b2b_idle_gap: busy got 1 expected 0"); end
    tests_run++; if (seen !== 1'b1 || n != 10) begin tests_failed++; $display("FAIL b2b_spacing: got %0d expected 10", n); end
    tests_run++; if (quotient !== 8'd7 || remainder !== 8'd4) begin tests_failed++; $display("FAIL b2b_second: got %0d/%0d expected 7/4", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] d;
    int bad;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      a = W'($urandom_range(0, 255));
      d = (i % 16 == 0) ? 8'd0 : W'($urandom_range(0, 255));
      run_div(a, d);
      tests_run++;
      if (res_timeout) begin
        tests_failed++; bad++;
        $display("FAIL rand%0d_timeout: no valid_o for %0d/%0d", i, a, d);
      end else if (d != 0) begin
        if ((int'(res_q) * int'(d) + int'(res_r)) != int'(a) || res_r >= d) begin
          tests_failed++; bad++;
          $display("FAIL rand%0d: %0d/%0d got q=%0d r=%0d expected q=%0d r=%0d", i, a, d, res_q, res_r, a / d, a % d);
        end
      end else begin
        if (res_q !== 8'hFF || res_r !== a) begin
          tests_failed++; bad++;
          $display("FAIL rand%0d_zero: %0d/0 got q=%0d r=%0d expected q=255 r=%0d", i, a, res_q, res_r, a);
        end
      end
    end
    $display("[TB] random: 2000 divisions, %0d bad", bad);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_by_zero();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
